plot_arbiter: RTL and testbench
===============================

// Module: plot_arbiter
// PURPOSE
//  N-channel pixel-plot arbiter; successor to the 4-way draw_select mux feeding vga_adapter.
//  Sources (player, blocks, init/clear, HUD...) push packed {x,y,colour} beats via valid/ready.
//  Round-robin grant; a channel's multi-pixel burst (sprite) is held atomic until in_last.
//  Registered out_x/out_y/out_colour/out_plot drive vga_adapter directly.
// PARAMETERS
//  NUM_CH  4    number of requesting channels (>=1)
//  X_W     8    x coordinate width
//  Y_W     7    y coordinate width
//  C_W     3    colour width
//  X_MAX   160  screen width; valid x range 0..X_MAX-1 (used by CLIP_EN)
//  Y_MAX   120  screen height; valid y range 0..Y_MAX-1 (used by CLIP_EN)
//  derived localparams: PIX_W = X_W+Y_W+C_W (18 at defaults); CH_W = max(1,$clog2(NUM_CH))
// PORTS
//  clock       in   1             system clock, all logic on rising edge
//  reset       in   1             synchronous, active-high
//  in_valid    in   NUM_CH        per-channel beat valid
//  in_last     in   NUM_CH        per-channel: beat is last of burst
//  in_pix      in   NUM_CH*PIX_W  ch i at [i*PIX_W +: PIX_W]; packed {x[PIX_W-1 -: X_W], y, colour[C_W-1:0]}
//  in_ready    out  NUM_CH        per-channel accept; at most one bit high
//  out_stall   in   1             downstream hold; blocks all acceptance
//  out_x       out  X_W           registered plot x
//  out_y       out  Y_W           registered plot y
//  out_colour  out  C_W           registered plot colour
//  out_plot    out  1             one-cycle write strobe to vga_adapter
//  out_ch      out  CH_W          channel that produced current out_* beat
//  busy        out  1             high while in LOCK state
//  drop_count  out  16            clipped-beat counter (CLIP_EN only)
// BEHAVIOUR
//  Reset: out_x/y/colour=0, out_plot=0, out_ch=0, busy=0, drop_count=0, rr_ptr=0, state=IDLE.
//  Accept on channel i: in_valid[i] & in_ready[i]; in_ready is combinational from state/valid/stall.
//  IDLE: winner = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
//   in_ready[winner]=~out_stall; none valid -> all ready 0, stay IDLE.
//   accept with in_last=1 -> stay IDLE, rr_ptr<=winner+1 mod NUM_CH.
//   accept with in_last=0 -> LOCK, owner<=winner.
//  LOCK: only in_ready[owner]=~out_stall; owner dropping valid holds lock, others still blocked.
//   accept with in_last=1 -> IDLE, rr_ptr<=owner+1 mod NUM_CH.
//  Latency: accepted beat appears on out_* with out_plot=1 on the next cycle (1 cycle).
//  No accept in a cycle -> out_plot=0 next cycle; out_x/y/colour/out_ch hold last values.
//  out_stall=1: no accept, state/rr_ptr frozen; stall is transparent to lock/last semantics.
//  NUM_CH=1: rr_ptr constant 0; grant always ch0.
//  Reset mid-burst: lock released, any partial burst abandoned; source must restart it.
//  in_last ignored on non-accepted cycles; in_pix sampled only on accept.
// CONFIGURATION
//  PLOT_CLIP_EN defined: accepted beat with x>=X_MAX or y>=Y_MAX is consumed (ready/last/
//   rr_ptr behave normally) but out_plot=0 next cycle, out_x/y/colour not updated;
//   drop_count +1 per clipped beat, saturating at 16'hFFFF.
//  PLOT_CLIP_EN undefined: no range check, every accepted beat is plotted; drop_count tied 0.
// TESTING
//  T1 reset: hold reset 2 cycles with all valid=1 -> in_ready=0, out_plot=0, all outputs 0.
//  T2 round-robin: ch0..3 valid, last=1 continuously -> grants 0,1,2,3,0; out_ch follows 1 cycle later.
//  T3 burst lock: ch1 sends 4 beats last=0,0,0,1 while ch0,ch2 valid -> ch1 gets 4 consecutive
//   grants, busy=1 for 3 cycles after first beat, next grant ch2.
//  T4 stall: during T3 burst assert out_stall 3 cycles -> no ready, out_plot=0, lock kept;
//   burst completes after release with pixel order intact.
//  T5 latency/data: ch3 beat {x=159,y=119,c=5} -> next cycle out_x=159,out_y=119,out_colour=5,plot=1.
//  T6 clip (PLOT_CLIP_EN): ch0 {x=160,y=10} then {x=5,y=120} -> both accepted, out_plot=0,
//   drop_count=2; without macro -> both plotted, drop_count=0.

Source files
------------

// File: rtl/plot_arbiter.sv
// N-channel round-robin pixel-plot arbiter with atomic bursts and registered plot outputs.
// Optional off-screen clipping is enabled by defining PLOT_CLIP_EN.
module plot_arbiter #(
    parameter int NUM_CH = 4,
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int C_W    = 3,
    parameter int X_MAX  = 160,
    parameter int Y_MAX  = 120
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_CH-1:0]                               in_valid,
    input  logic [NUM_CH-1:0]                               in_last,
    input  logic [NUM_CH*(X_W+Y_W+C_W)-1:0]                 in_pix,
    output logic [NUM_CH-1:0]                               in_ready,
    input  logic                                            out_stall,
    output logic [X_W-1:0]                                  out_x,
    output logic [Y_W-1:0]                                  out_y,
    output logic [C_W-1:0]                                  out_colour,
    output logic                                            out_plot,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  out_ch,
    output logic                                            busy,
    output logic [15:0]                                     drop_count
);
    localparam int PIX_W = X_W + Y_W + C_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || X_MAX > (1 << X_W) || Y_MAX > (1 << Y_W)) begin : g_bad_params
        $error("plot_arbiter: illegal parameter combination");
    end

    typedef enum logic [0:0] {ST_IDLE, ST_LOCK} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] owner_q, owner_d;
    logic [X_W-1:0]  out_x_q, out_x_d;
    logic [Y_W-1:0]  out_y_q, out_y_d;
    logic [C_W-1:0]  out_colour_q, out_colour_d;
    logic            out_plot_q, out_plot_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;

    logic            win_found;
    logic [CH_W-1:0] win_ch;
    logic [CH_W-1:0] scan_ch;
    logic [CH_W-1:0] acc_ch;
    logic [CH_W-1:0] acc_next;
    logic            grant_ok;
    logic            accept;
    logic            acc_last;
    logic            clip;
    logic [PIX_W-1:0] acc_pix;
    logic [X_W-1:0]  acc_x;
    logic [Y_W-1:0]  acc_y;
    logic [C_W-1:0]  acc_c;

    // Round-robin scan starts at rr_ptr; in LOCK the owner is the only candidate.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        scan_ch   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_ch = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            if (!win_found && in_valid[scan_ch]) begin
                win_found = 1'b1;
                win_ch    = scan_ch;
            end
        end
        acc_ch   = (state_q == ST_LOCK) ? owner_q : win_ch;
        grant_ok = (state_q == ST_LOCK) || win_found;
        in_ready = '0;
        if (!reset && !out_stall && grant_ok) begin
            in_ready[acc_ch] = 1'b1;
        end
        accept   = |(in_valid & in_ready);
        acc_last = in_last[acc_ch];
        acc_next = (acc_ch == CH_W'(NUM_CH - 1)) ? '0 : acc_ch + CH_W'(1);
        acc_pix  = in_pix[acc_ch*PIX_W +: PIX_W];
        acc_x    = acc_pix[PIX_W-1 -: X_W];
        acc_y    = acc_pix[C_W +: Y_W];
        acc_c    = acc_pix[C_W-1:0];
`ifdef PLOT_CLIP_EN
        clip     = (int'(acc_x) >= X_MAX) || (int'(acc_y) >= Y_MAX);
`else
        clip     = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (accept) begin
            if (acc_last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = acc_next;
            end else begin
                state_d  = ST_LOCK;
                owner_d  = acc_ch;
            end
        end
    end

    // Clipped beats are consumed but leave the plotted values untouched.
    always_comb begin
        out_plot_d   = accept && !clip;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_colour_d = out_colour_q;
        out_ch_d     = out_ch_q;
        if (out_plot_d) begin
            out_x_d      = acc_x;
            out_y_d      = acc_y;
            out_colour_d = acc_c;
            out_ch_d     = acc_ch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_colour_q <= '0;
            out_plot_q   <= 1'b0;
            out_ch_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_colour_q <= out_colour_d;
            out_plot_q   <= out_plot_d;
            out_ch_q     <= out_ch_d;
        end
    end

`ifdef PLOT_CLIP_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (accept && clip && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 16'd0;
`endif

    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_colour_q;
    assign out_plot   = out_plot_q;
    assign out_ch     = out_ch_q;
    assign busy       = (state_q == ST_LOCK);

endmodule

// File: tb/tb_plot_arbiter.sv
// Randomised bench for plot_arbiter against a burst/round-robin reference model.
// Directed openers cover reset, rotation, burst lock, stall, data latency and clipping.
module tb_plot_arbiter;
  localparam int NCH = 4;
  localparam int PW  = 18;

  logic            clock = 1'b0;
  logic            reset;
  logic [NCH-1:0]  in_valid;
  logic [NCH-1:0]  in_last;
  logic [NCH*PW-1:0] in_pix;
  logic [NCH-1:0]  in_ready;
  logic            out_stall;
  logic [7:0]      out_x;
  logic [6:0]      out_y;
  logic [2:0]      out_colour;
  logic            out_plot;
  logic [1:0]      out_ch;
  logic            busy;
  logic [15:0]     drop_count;

  plot_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_pix     (in_pix),
    .in_ready   (in_ready),
    .out_stall  (out_stall),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .out_plot   (out_plot),
    .out_ch     (out_ch),
    .busy       (busy),
    .drop_count (drop_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // reference model: next channel to favour, current burst owner (-1 = none)
  int          m_ptr;
  int          m_owner;
  logic [3:0]  m_ready;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  logic [2:0]  m_c;
  logic [1:0]  m_ch;
  logic        m_plot;
  logic [15:0] m_drop;
  logic [19:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_pix(input int ch, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    in_pix[ch*PW +: PW] = {x, y, c};
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_x     = '0;
    m_y     = '0;
    m_c     = '0;
    m_ch    = '0;
    m_plot  = 1'b0;
    m_drop  = '0;
    exp_q.delete();
  endtask

  // driver: one clock cycle of stimulus, with ready checked before the edge
  // and every output checked just after it
  task automatic run_cycle(input logic [3:0] v, input logic [3:0] l, input logic st, input logic rs);
    int          a;
    logic        found;
    logic        clipped;
    logic [17:0] p;
    logic [19:0] e;
    @(negedge clock);
    in_valid  = v;
    in_last   = l;
    out_stall = st;
    reset     = rs;
    #1;
    m_ready = '0;
    if (!rs && !st) begin
      if (m_owner >= 0) begin
        m_ready[m_owner] = 1'b1;
      end else begin
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          if (!found && v[(m_ptr + k) % NCH]) begin
            found = 1'b1;
            m_ready[(m_ptr + k) % NCH] = 1'b1;
          end
        end
      end
    end
    check_eq("in_ready", 32'(in_ready), 32'(m_ready));
    a = -1;
    for (int k = 0; k < NCH; k++) begin
      if (v[k] && m_ready[k]) a = k;
    end
    p = (a >= 0) ? in_pix[a*PW +: PW] : '0;
    @(posedge clock);
    #1;
    m_plot = 1'b0;
    if (rs) begin
      model_reset();
    end else if (a >= 0) begin
      clipped = 1'b0;
`ifdef PLOT_CLIP_EN
      clipped = (p[17:10] >= 8'd160) || (p[9:3] >= 7'd120);
`endif
      if (clipped) begin
        if (m_drop != 16'hFFFF) m_drop++;
      end else begin
        exp_q.push_back({2'(a), p});
      end
      if (l[a]) begin
        m_owner = -1;
        m_ptr   = (a + 1) % NCH;
      end else begin
        m_owner = a;
      end
    end
    if (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      m_plot = 1'b1;
      m_ch   = e[19:18];
      m_x    = e[17:10];
      m_y    = e[9:3];
      m_c    = e[2:0];
    end
    check_eq("out_plot",   32'(out_plot),   32'(m_plot));
    check_eq("out_x",      32'(out_x),      32'(m_x));
    check_eq("out_y",      32'(out_y),      32'(m_y));
    check_eq("out_colour", 32'(out_colour), 32'(m_c));
    check_eq("out_ch",     32'(out_ch),     32'(m_ch));
    check_eq("busy",       32'(busy),       32'(m_owner >= 0));
    check_eq("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  initial begin
    logic [15:0] drop_before;
    logic [3:0]  v;
    logic [3:0]  l;
    in_valid  = '0;
    in_last   = '0;
    in_pix    = '0;
    out_stall = 1'b0;
    reset     = 1'b1;
    model_reset();

    // reset with every channel requesting
    run_cycle(4'hF, 4'hF, 1'b0, 1'b1);
    run_cycle(4'hF, 4'hF, 1'b0, 1'b1);
    check_eq("t1_ready", 32'(in_ready), 32'd0);
    check_eq("t1_plot",  32'(out_plot), 32'd0);

    // round-robin rotation with single-beat requests
    for (int k = 0; k < NCH; k++) set_pix(k, 8'(10 * k + 1), 7'(k + 2), 3'(k));
    for (int k = 0; k < 5; k++) begin
      run_cycle(4'hF, 4'hF, 1'b0, 1'b0);
      check_eq("t2_ch", 32'(out_ch), 32'(k % NCH));
    end

    // ch1 four-beat burst while ch0/ch2 wait, with a 3-cycle stall mid-burst
    for (int b = 0; b < 4; b++) begin
      set_pix(1, 8'(20 + b), 7'(30 + b), 3'(b));
      l = (b == 3) ? 4'b1111 : 4'b1101;
      run_cycle(4'b0111, l, 1'b0, 1'b0);
      check_eq("t3_ch",   32'(out_ch), 32'd1);
      check_eq("t3_x",    32'(out_x),  32'(20 + b));
      check_eq("t3_busy", 32'(busy),   32'(b < 3));
      if (b == 1) begin
        for (int s = 0; s < 3; s++) begin
          run_cycle(4'b0111, 4'b1101, 1'b1, 1'b0);
          check_eq("t4_ready", 32'(in_ready), 32'd0);
          check_eq("t4_plot",  32'(out_plot), 32'd0);
          check_eq("t4_busy",  32'(busy),     32'd1);
        end
      end
    end
    run_cycle(4'b0101, 4'b1111, 1'b0, 1'b0);
    check_eq("t3_next", 32'(out_ch), 32'd2);

    // corner pixel latency and data
    set_pix(3, 8'd159, 7'd119, 3'd5);
    run_cycle(4'b1000, 4'b1000, 1'b0, 1'b0);
    check_eq("t5_x",    32'(out_x),      32'd159);
    check_eq("t5_y",    32'(out_y),      32'd119);
    check_eq("t5_c",    32'(out_colour), 32'd5);
    check_eq("t5_plot", 32'(out_plot),   32'd1);

    // off-screen beats
    drop_before = m_drop;
    set_pix(0, 8'd160, 7'd10, 3'd1);
    run_cycle(4'b0001, 4'b0001, 1'b0, 1'b0);
`ifdef PLOT_CLIP_EN
    check_eq("t6_plot_a", 32'(out_plot), 32'd0);
`else
    check_eq("t6_plot_a", 32'(out_plot), 32'd1);
`endif
    set_pix(0, 8'd5, 7'd120, 3'd2);
    run_cycle(4'b0001, 4'b0001, 1'b0, 1'b0);
`ifdef PLOT_CLIP_EN
    check_eq("t6_plot_b", 32'(out_plot),   32'd0);
    check_eq("t6_drop",   32'(drop_count), 32'(drop_before) + 32'd2);
`else
    check_eq("t6_plot_b", 32'(out_plot),   32'd1);
    check_eq("t6_drop",   32'(drop_count), 32'd0);
`endif

    // randomised traffic: bursts, dropped valids, stalls, occasional reset
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NCH; k++) begin
        set_pix(k, 8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
      end
      v = 4'($urandom_range(0, 15));
      for (int k = 0; k < NCH; k++) l[k] = ($urandom_range(0, 2) == 0);
      run_cycle(v, l, $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
